// File: rtl/core_ma_pkg.sv
// core_ma_pkg: shared types and constants for the memory-access stage.
// Holds mem-op encodings, the MA FSM state type, trap causes and MW bundle.
package core_ma_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  localparam logic [31:0] MA_CAUSE_LD_MISALIGN = 32'd4;
  localparam logic [31:0] MA_CAUSE_ST_MISALIGN = 32'd6;

  typedef enum logic {
    MA_IDLE,
    MA_WAIT_RSP
  } ma_state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] data;
    logic        data_valid;
    logic [11:0] csr;
    logic        csr_write;
    logic [31:0] csr_data;
  } mw_t;

  // Loads know BU/HU; for stores anything but B/H is a word.
  function automatic logic ma_is_byte(input logic [2:0] op,
                                      input logic       ld);
    return ld ? (op == MEM_OP_B || op == MEM_OP_BU)
              : (op == MEM_OP_B);
  endfunction

  function automatic logic ma_is_half(input logic [2:0] op,
                                      input logic       ld);
    return ld ? (op == MEM_OP_H || op == MEM_OP_HU)
              : (op == MEM_OP_H);
  endfunction

endpackage

// File: rtl/core_ma_align.sv
// core_ma_align: combinational lane logic for the MA stage.
// Ports: st_* -> byte enables/replicated store data; ld_* -> extended load.
module core_ma_align
  import core_ma_pkg::*;
(
  input  logic [2:0]  st_op_i,
  input  logic [1:0]  st_a_i,
  input  logic [31:0] st_data_i,
  input  logic        st_is_load_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_a_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    if (!st_is_load_i) begin
      unique case (st_op_i)
        MEM_OP_B: begin
          be_o    = 4'b0001 << st_a_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        MEM_OP_H: begin
          be_o    = 4'b0011 << {st_a_i[1], 1'b0};
          wdata_o = {2{st_data_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = st_data_i;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = rdata_i[7:0];
    unique case (ld_a_i)
      2'd0: ld_byte = rdata_i[7:0];
      2'd1: ld_byte = rdata_i[15:8];
      2'd2: ld_byte = rdata_i[23:16];
      2'd3: ld_byte = rdata_i[31:24];
      default: ld_byte = rdata_i[7:0];
    endcase
    ld_half = ld_a_i[1] ? rdata_i[31:16]
                        : rdata_i[15:0];
  end

  always_comb begin
    ld_data_o = rdata_i;
    unique case (ld_op_i)
      MEM_OP_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_OP_BU: ld_data_o = {24'd0, ld_byte};
      MEM_OP_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEM_OP_HU: ld_data_o = {16'd0, ld_half};
      default:   ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/core_ma.sv
// core_ma: RV32 memory-access stage, EM -> dbus -> MW, one outstanding op.
// Ports: em_* in, dbus_* bus, mw_* out; misalign trap if CORE_MA_MISALIGN_CHECK_EN.
module core_ma
  import core_ma_pkg::*;
#(
  parameter logic STORE_ACK = 1'b1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        em_valid,
  input  logic        em_start_handle,
  output logic        em_ready,
  input  logic [31:0] em_reg_data_mem_addr,
  input  logic [31:0] em_csr_data_mem_data,
  input  logic        em_mem_read,
  input  logic        em_mem_write,
  input  logic [2:0]  em_mem_op_type,
  input  logic [4:0]  em_rd,
  input  logic        em_reg_write,
  input  logic [11:0] em_csr,
  input  logic        em_csr_write,
  output logic        dbus_cmd_valid,
  input  logic        dbus_cmd_ready,
  output logic        dbus_cmd_write,
  output logic [31:0] dbus_cmd_addr,
  output logic [31:0] dbus_cmd_wdata,
  output logic [3:0]  dbus_cmd_be,
  input  logic        dbus_rsp_valid,
  input  logic [31:0] dbus_rsp_rdata,
  output logic        mw_valid,
  output logic [4:0]  mw_rd,
  output logic        mw_reg_write,
  output logic [31:0] mw_reg_write_data,
  output logic        mw_mem_data_valid,
  output logic [11:0] mw_csr,
  output logic        mw_csr_write,
  output logic [31:0] mw_csr_data
`ifdef CORE_MA_MISALIGN_CHECK_EN
  ,
  output logic        ma_misalign_valid,
  output logic [31:0] ma_misalign_cause,
  output logic [31:0] ma_misalign_addr
`endif
);

  ma_state_t   state_q, state_d;
  mw_t         mw_q;
  logic        ld_q;
  logic [2:0]  op_q;
  logic [1:0]  a_q;

  logic        is_mem, is_load, mis, hs, waits;
  logic        rsp_hit;
  logic [31:0] ld_data;
  logic        unused_start;

  assign unused_start = em_start_handle;

  assign is_mem  = em_mem_read | em_mem_write;
  assign is_load = em_mem_read;

`ifdef CORE_MA_MISALIGN_CHECK_EN
  logic        mis_valid_q;
  logic [31:0] mis_cause_q;
  logic [31:0] mis_addr_q;
  logic        op_b, op_h;

  assign op_b = ma_is_byte(em_mem_op_type, is_load);
  assign op_h = ma_is_half(em_mem_op_type, is_load);
  assign mis  = is_mem &&
    ((op_h && em_reg_data_mem_addr[0]) ||
     (!op_b && !op_h &&
      em_reg_data_mem_addr[1:0] != 2'b00));

  assign ma_misalign_valid = mis_valid_q;
  assign ma_misalign_cause = mis_cause_q;
  assign ma_misalign_addr  = mis_addr_q;

  always_ff @(posedge clk) begin
    if (rest) begin
      mis_valid_q <= 1'b0;
      mis_cause_q <= '0;
      mis_addr_q  <= '0;
    end else begin
      mis_valid_q <= hs && mis;
      if (hs && mis) begin
        mis_cause_q <= is_load ? MA_CAUSE_LD_MISALIGN
                               : MA_CAUSE_ST_MISALIGN;
        mis_addr_q  <= em_reg_data_mem_addr;
      end
    end
  end
`else
  assign mis = 1'b0;
`endif

  // Accepted ops that still owe the bus a response.
  assign waits = is_mem && !mis &&
                 (is_load || STORE_ACK);

  always_comb begin
    em_ready       = 1'b0;
    dbus_cmd_valid = 1'b0;
    if (!rest && state_q == MA_IDLE) begin
      if (!is_mem || mis) begin
        em_ready = 1'b1;
      end else begin
        em_ready       = dbus_cmd_ready;
        dbus_cmd_valid = em_valid;
      end
    end
  end

  assign hs      = em_valid && em_ready;
  assign rsp_hit = state_q == MA_WAIT_RSP &&
                   dbus_rsp_valid;

  assign dbus_cmd_write = !is_load;
  assign dbus_cmd_addr  =
    {em_reg_data_mem_addr[31:2], 2'b00};

  core_ma_align u_align (
    .st_op_i      (em_mem_op_type),
    .st_a_i       (em_reg_data_mem_addr[1:0]),
    .st_data_i    (em_csr_data_mem_data),
    .st_is_load_i (is_load),
    .be_o         (dbus_cmd_be),
    .wdata_o      (dbus_cmd_wdata),
    .ld_op_i      (op_q),
    .ld_a_i       (a_q),
    .rdata_i      (dbus_rsp_rdata),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MA_IDLE:
        if (hs && waits) state_d = MA_WAIT_RSP;
      MA_WAIT_RSP:
        if (dbus_rsp_valid) state_d = MA_IDLE;
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) state_q <= MA_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      mw_q <= '0;
      ld_q <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
    end else if (hs) begin
      mw_q.valid      <= 1'b1;
      mw_q.rd         <= em_rd;
      mw_q.reg_write  <= em_reg_write && !mis;
      mw_q.data       <= em_reg_data_mem_addr;
      mw_q.data_valid <= !waits;
      mw_q.csr        <= em_csr;
      mw_q.csr_write  <= em_csr_write;
      mw_q.csr_data   <= em_csr_data_mem_data;
      ld_q <= is_load;
      op_q <= em_mem_op_type;
      a_q  <= em_reg_data_mem_addr[1:0];
    end else if (rsp_hit) begin
      if (ld_q) mw_q.data <= ld_data;
      mw_q.data_valid <= 1'b1;
    end else if (mw_q.data_valid) begin
      mw_q.valid <= 1'b0;
    end
  end

  assign mw_valid          = mw_q.valid;
  assign mw_rd             = mw_q.rd;
  assign mw_reg_write      = mw_q.reg_write;
  assign mw_reg_write_data = mw_q.data;
  assign mw_mem_data_valid = mw_q.data_valid;
  assign mw_csr            = mw_q.csr;
  assign mw_csr_write      = mw_q.csr_write;
  assign mw_csr_data       = mw_q.csr_data;

endmodule

// File: tb/tb_core_ma.sv
// tb_core_ma: directed-vector bench for the MA stage.
// Expected values are hand-computed from the stage behaviour.
module tb_core_ma;

  logic        clk = 1'b0;
  logic        rest;
  logic        em_valid, em_start_handle, em_ready;
  logic [31:0] em_addr, em_data;
  logic        em_mem_read, em_mem_write;
  logic [2:0]  em_op;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mw_valid, mw_reg_write, mw_mdv, mw_csr_write;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data, mw_csr_data;
  logic [11:0] mw_csr;
`ifdef CORE_MA_MISALIGN_CHECK_EN
  logic        mis_valid;
  logic [31:0] mis_cause, mis_addr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_ma dut (
    .clk                  (clk),
    .rest                 (rest),
    .em_valid             (em_valid),
    .em_start_handle      (em_start_handle),
    .em_ready             (em_ready),
    .em_reg_data_mem_addr (em_addr),
    .em_csr_data_mem_data (em_data),
    .em_mem_read          (em_mem_read),
    .em_mem_write         (em_mem_write),
    .em_mem_op_type       (em_op),
    .em_rd                (em_rd),
    .em_reg_write         (em_reg_write),
    .em_csr               (em_csr),
    .em_csr_write         (em_csr_write),
    .dbus_cmd_valid       (cmd_valid),
    .dbus_cmd_ready       (cmd_ready),
    .dbus_cmd_write       (cmd_write),
    .dbus_cmd_addr        (cmd_addr),
    .dbus_cmd_wdata       (cmd_wdata),
    .dbus_cmd_be          (cmd_be),
    .dbus_rsp_valid       (rsp_valid),
    .dbus_rsp_rdata       (rsp_rdata),
    .mw_valid             (mw_valid),
    .mw_rd                (mw_rd),
    .mw_reg_write         (mw_reg_write),
    .mw_reg_write_data    (mw_data),
    .mw_mem_data_valid    (mw_mdv),
    .mw_csr               (mw_csr),
    .mw_csr_write         (mw_csr_write),
    .mw_csr_data          (mw_csr_data)
`ifdef CORE_MA_MISALIGN_CHECK_EN
    ,
    .ma_misalign_valid    (mis_valid),
    .ma_misalign_cause    (mis_cause),
    .ma_misalign_addr     (mis_addr)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic em_mem(input logic rd_, input logic wr_,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] d);
    em_valid     = 1'b1;
    em_mem_read  = rd_;
    em_mem_write = wr_;
    em_op        = op;
    em_addr      = a;
    em_data      = d;
    em_reg_write = 1'b1;
    em_rd        = 5'd7;
  endtask

  task automatic em_idle();
    em_valid     = 1'b0;
    em_mem_read  = 1'b0;
    em_mem_write = 1'b0;
  endtask

  logic [31:0] alu_v [3];

  initial begin
    rest = 1'b1;
    em_start_handle = 1'b0;
    em_csr = 12'h300;
    em_csr_write = 1'b0;
    em_op = 3'b000;
    em_addr = '0;
    em_data = '0;
    em_rd = '0;
    em_reg_write = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    em_idle();
    tick();
    tick();
    chk("rst_mw_valid", {31'd0, mw_valid}, 32'd0);
    chk("rst_mw_data", mw_data, 32'd0);
    chk("rst_mw_mdv", {31'd0, mw_mdv}, 32'd0);
    chk("rst_mw_csr", {20'd0, mw_csr}, 32'd0);
    em_valid = 1'b1;
    #1;
    chk("rst_em_ready", {31'd0, em_ready}, 32'd0);
    em_valid = 1'b0;
    rest = 1'b0;
    tick();

    // Three back-to-back ALU ops.
    alu_v[0] = 32'h11;
    alu_v[1] = 32'h22;
    alu_v[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      em_valid     = 1'b1;
      em_addr      = alu_v[i];
      em_data      = 32'h55;
      em_reg_write = 1'b1;
      em_rd        = 5'd1;
      #1;
      chk("alu_ready", {31'd0, em_ready}, 32'd1);
      chk("alu_cmd_v", {31'd0, cmd_valid}, 32'd0);
      tick();
      chk("alu_data", mw_data, alu_v[i]);
      chk("alu_mdv", {31'd0, mw_mdv}, 32'd1);
      chk("alu_valid", {31'd0, mw_valid}, 32'd1);
    end
    chk("alu_csr_data", mw_csr_data, 32'h55);
    em_idle();
    tick();
    chk("alu_retire", {31'd0, mw_valid}, 32'd0);

    // LB sign-extend, response two cycles after acceptance.
    em_mem(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0);
    cmd_ready = 1'b1;
    #1;
    chk("lb_cmd_v", {31'd0, cmd_valid}, 32'd1);
    chk("lb_addr", cmd_addr, 32'h1000);
    chk("lb_be", {28'd0, cmd_be}, 32'hF);
    chk("lb_write", {31'd0, cmd_write}, 32'd0);
    chk("lb_ready", {31'd0, em_ready}, 32'd1);
    tick();
    em_idle();
    cmd_ready = 1'b0;
    #1;
    chk("lb_valid", {31'd0, mw_valid}, 32'd1);
    chk("lb_mdv0", {31'd0, mw_mdv}, 32'd0);
    em_valid = 1'b1;
    #1;
    chk("lb_wait_rdy", {31'd0, em_ready}, 32'd0);
    chk("lb_wait_cmd", {31'd0, cmd_valid}, 32'd0);
    em_valid = 1'b0;
    tick();
    chk("lb_mdv1", {31'd0, mw_mdv}, 32'd0);
    rsp_valid = 1'b1;
    rsp_rdata = 32'h80FF_FFFF;
    tick();
    rsp_valid = 1'b0;
    chk("lb_mdv2", {31'd0, mw_mdv}, 32'd1);
    chk("lb_data", mw_data, 32'hFFFF_FF80);
    tick();
    chk("lb_retire", {31'd0, mw_valid}, 32'd0);

    // LHU upper halfword, response one cycle after acceptance.
    em_mem(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0);
    cmd_ready = 1'b1;
    tick();
    em_idle();
    cmd_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hBEEF_1234;
    tick();
    rsp_valid = 1'b0;
    chk("lhu_data", mw_data, 32'h0000_BEEF);
    chk("lhu_mdv", {31'd0, mw_mdv}, 32'd1);
    tick();

    // SH stalled by cmd_ready for three cycles.
    em_mem(1'b0, 1'b1, 3'b001, 32'h3002, 32'h0000_ABCD);
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_stall_v", {31'd0, cmd_valid}, 32'd1);
      chk("sh_stall_r", {31'd0, em_ready}, 32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    #1;
    chk("sh_ready", {31'd0, em_ready}, 32'd1);
    chk("sh_be", {28'd0, cmd_be}, 32'hC);
    chk("sh_wdata", cmd_wdata, 32'hABCD_ABCD);
    chk("sh_write", {31'd0, cmd_write}, 32'd1);
    chk("sh_addr", cmd_addr, 32'h3000);
    tick();
    em_idle();
    cmd_ready = 1'b0;
    chk("sh_mdv0", {31'd0, mw_mdv}, 32'd0);
    chk("sh_valid", {31'd0, mw_valid}, 32'd1);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("sh_mdv1", {31'd0, mw_mdv}, 32'd1);
    tick();

    // SB lane replication at byte 1.
    em_mem(1'b0, 1'b1, 3'b000, 32'h5001, 32'h1234_5678);
    #1;
    chk("sb_be", {28'd0, cmd_be}, 32'h2);
    chk("sb_wdata", cmd_wdata, 32'h7878_7878);
    em_idle();
    tick();

    // Reset while waiting; the stale response must be ignored.
    em_mem(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0);
    cmd_ready = 1'b1;
    tick();
    em_idle();
    cmd_ready = 1'b0;
    rest = 1'b1;
    tick();
    rest = 1'b0;
    chk("rw_valid", {31'd0, mw_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_rdata = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    chk("rw_valid2", {31'd0, mw_valid}, 32'd0);
    chk("rw_mdv", {31'd0, mw_mdv}, 32'd0);
    em_valid     = 1'b1;
    em_addr      = 32'h77;
    em_reg_write = 1'b1;
    #1;
    chk("rw_ready", {31'd0, em_ready}, 32'd1);
    tick();
    em_idle();
    chk("rw_next", mw_data, 32'h77);
    chk("rw_next_v", {31'd0, mw_valid}, 32'd1);
    tick();

`ifdef CORE_MA_MISALIGN_CHECK_EN
    // Misaligned LW traps without touching the bus.
    em_mem(1'b1, 1'b0, 3'b010, 32'h4001, 32'h0);
    cmd_ready = 1'b1;
    #1;
    chk("mis_cmd_v", {31'd0, cmd_valid}, 32'd0);
    chk("mis_ready", {31'd0, em_ready}, 32'd1);
    tick();
    em_idle();
    cmd_ready = 1'b0;
    chk("mis_valid", {31'd0, mis_valid}, 32'd1);
    chk("mis_cause", mis_cause, 32'd4);
    chk("mis_addr", mis_addr, 32'h4001);
    chk("mis_rw", {31'd0, mw_reg_write}, 32'd0);
    chk("mis_mdv", {31'd0, mw_mdv}, 32'd1);
    tick();
    chk("mis_pulse", {31'd0, mis_valid}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
